// File: rtl/keypad_scan_ctrl.sv
// Row-strobed 8x4 key matrix scanner with whole-scan debounce and a valid/ack key handshake.
// Optional ghosting guard and multi_key flag: define KEYPAD_SCAN_MULTI_EN.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] row_n,
  input  logic [3:0] col_n,
  output logic       key_valid,
  output logic [4:0] key_code,
  input  logic       key_ack,
  output logic       multi_key
);

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE);

  typedef enum logic [1:0] {SCAN, HOLD, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  col_s1_q, col_s2_q;
  logic [7:0]  div_q, div_d;
  logic [2:0]  row_q, row_d;
  logic        cand_valid_q, cand_valid_d;
  logic [4:0]  cand_code_q, cand_code_d;
  logic        cand_multi_q, cand_multi_d;
  logic        prev_valid_q, prev_valid_d;
  logic [4:0]  prev_code_q, prev_code_d;
  logic [3:0]  match_q, match_d, match_next;
  logic [3:0]  empty_q, empty_d, empty_inc;
  logic        key_valid_q, key_valid_d;
  logic [4:0]  key_code_q, key_code_d;

  logic        sample, scan_end, first_row, releasing;
  logic [3:0]  pressed;
  logic        row_hit, row_multi;
  logic [1:0]  low_col;
  logic        acc_valid, acc_multi;
  logic        scan_valid, scan_multi, eff_valid;
  logic [4:0]  scan_code;

  always_comb begin
    sample    = (div_q == DIV_LAST);
    scan_end  = sample && (row_q == 3'd7);
    first_row = (row_q == 3'd0);
    div_d     = sample ? 8'd0 : div_q + 8'd1;
    row_d     = sample ? row_q + 3'd1 : row_q;

    pressed   = ~col_s2_q;
    row_hit   = |pressed;
    row_multi = |(pressed & (pressed - 4'd1));
    if (pressed[0])      low_col = 2'd0;
    else if (pressed[1]) low_col = 2'd1;
    else if (pressed[2]) low_col = 2'd2;
    else                 low_col = 2'd3;

    // Row 0 starts a fresh scan, so the previous scan's accumulators are ignored there.
    acc_valid  = cand_valid_q & ~first_row;
    acc_multi  = cand_multi_q & ~first_row;
    scan_valid = acc_valid | row_hit;
    scan_code  = acc_valid ? cand_code_q : {row_q, low_col};
    scan_multi = acc_multi | row_multi | (acc_valid & row_hit);

    cand_valid_d = sample ? scan_valid : cand_valid_q;
    cand_code_d  = sample ? scan_code  : cand_code_q;
    cand_multi_d = sample ? scan_multi : cand_multi_q;

`ifdef KEYPAD_SCAN_MULTI_EN
    eff_valid = scan_valid & ~scan_multi;
`else
    eff_valid = scan_valid;
`endif

    if (!eff_valid)                                      match_next = 4'd0;
    else if (!prev_valid_q || (prev_code_q != scan_code)) match_next = 4'd1;
    else if (match_q < DEB_MAX)                          match_next = match_q + 4'd1;
    else                                                 match_next = match_q;

    match_d      = scan_end ? match_next : match_q;
    prev_valid_d = scan_end ? eff_valid  : prev_valid_q;
    prev_code_d  = scan_end ? scan_code  : prev_code_q;

    state_d     = state_q;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    empty_d     = empty_q;
    empty_inc   = empty_q + 4'd1;

    case (state_q)
      SCAN: begin
        empty_d = 4'd0;
        if (scan_end && eff_valid && (match_next == DEB_MAX)) begin
          key_code_d  = scan_code;
          key_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (key_ack) begin
          key_valid_d = 1'b0;
          state_d     = RELEASE;
        end
      end
      RELEASE: ;
      default: state_d = SCAN;
    endcase

    // An ack landing on an end-of-scan edge already lets that scan count toward release.
    releasing = (state_q == RELEASE) || ((state_q == HOLD) && key_ack);
    if (releasing && scan_end) begin
      if (eff_valid) begin
        empty_d = 4'd0;
      end else if (empty_inc == DEB_MAX) begin
        empty_d = 4'd0;
        match_d = 4'd0;
        state_d = SCAN;
      end else begin
        empty_d = empty_inc;
      end
    end
  end

`ifdef KEYPAD_SCAN_MULTI_EN
  logic multi_key_q, multi_key_d;

  always_comb begin
    multi_key_d = scan_end ? scan_multi : multi_key_q;
  end

  always_ff @(posedge clk) begin
    if (rst) multi_key_q <= 1'b0;
    else     multi_key_q <= multi_key_d;
  end

  assign multi_key = multi_key_q;
`else
  assign multi_key = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SCAN;
      col_s1_q     <= 4'd0;
      col_s2_q     <= 4'd0;
      div_q        <= 8'd0;
      row_q        <= 3'd0;
      cand_valid_q <= 1'b0;
      cand_code_q  <= 5'd0;
      cand_multi_q <= 1'b0;
      prev_valid_q <= 1'b0;
      prev_code_q  <= 5'd0;
      match_q      <= 4'd0;
      empty_q      <= 4'd0;
      key_valid_q  <= 1'b0;
      key_code_q   <= 5'd0;
    end else begin
      state_q      <= state_d;
      col_s1_q     <= col_n;
      col_s2_q     <= col_s1_q;
      div_q        <= div_d;
      row_q        <= row_d;
      cand_valid_q <= cand_valid_d;
      cand_code_q  <= cand_code_d;
      cand_multi_q <= cand_multi_d;
      prev_valid_q <= prev_valid_d;
      prev_code_q  <= prev_code_d;
      match_q      <= match_d;
      empty_q      <= empty_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
    end
  end

  assign row_n     = ~(8'b1 << row_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a key-matrix model drives col_n from row_n, and a
// scoreboard of expected key events (code and cycle) is drained by a rising-key_valid monitor.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_ack;
  logic       multi_key;

  logic [7:0][3:0] keys;
  int cyc = 0;
  int check_count = 0;
  int pass_count = 0;
  logic last_valid = 1'b0;

  typedef struct {
    int code;
    int cycle;
  } exp_t;
  exp_t sb[$];

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ack   (key_ack),
    .multi_key (multi_key)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Switch matrix: a pressed key pulls its column low while its row is strobed.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 8; r++)
      if (!row_n[r]) col_n = col_n & ~keys[r];
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0][3:0] k, input logic ack);
    keys    = k;
    key_ack = ack;
  endtask

  task automatic wait_until(input int k);
    int guard = 0;
    while (cyc < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != k) begin
      check_count++;
      $display("[TB] FAIL wait_cycle: reached %0d, expected %0d", cyc, k);
    end
  endtask

  function automatic logic [7:0][3:0] one_key(input int r, input int c);
    logic [7:0][3:0] k;
    k = '0;
    k[r][c] = 1'b1;
    return k;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (key_valid && !last_valid) begin
      if (sb.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_key: got key_valid with code %0d at cycle %0d, expected none", key_code, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("key_code", int'(key_code), e.code);
        checkOutput("key_rise_cycle", cyc, e.cycle);
      end
    end
    last_valid = key_valid;
  end

  initial begin
    logic [7:0][3:0] k;
    rst = 1'b1;
    applyStimulus(one_key(5, 2), 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state and row strobe walk with row 5 col 2 held.
    checkOutput("reset_row_n", int'(row_n), 8'hFE);
    checkOutput("reset_key_valid", int'(key_valid), 0);
    checkOutput("reset_key_code", int'(key_code), 0);
    checkOutput("reset_multi_key", int'(multi_key), 0);
    sb.push_back('{code: 22, cycle: 64});
    wait_until(19); checkOutput("row_n_c19", int'(row_n), 8'hEF);
    wait_until(20); checkOutput("row_n_c20", int'(row_n), 8'hDF);
    wait_until(23); checkOutput("row_n_c23", int'(row_n), 8'hDF);
    wait_until(24); checkOutput("row_n_c24", int'(row_n), 8'hBF);
    wait_until(63); checkOutput("valid_before_debounce", int'(key_valid), 0);

    // Release before ack keeps key_valid; ack drops it one cycle later.
    wait_until(66);
    applyStimulus('0, 1'b0);
    checkOutput("valid_c66", int'(key_valid), 1);
    wait_until(70);
    checkOutput("valid_c70", int'(key_valid), 1);
    checkOutput("code_c70", int'(key_code), 22);
    applyStimulus('0, 1'b1);
    wait_until(71);
    applyStimulus('0, 1'b0);
    checkOutput("valid_after_ack", int'(key_valid), 0);

    // One-scan glitch on row 1 col 0 is never reported; row 2 col 3 is after two scans.
    wait_until(128);
    checkOutput("valid_release", int'(key_valid), 0);
    applyStimulus(one_key(1, 0), 1'b0);
    wait_until(160);
    applyStimulus(one_key(2, 3), 1'b0);
    sb.push_back('{code: 11, cycle: 224});
    wait_until(223); checkOutput("valid_c223", int'(key_valid), 0);
    wait_until(230);
    checkOutput("code_c230", int'(key_code), 11);
    applyStimulus('0, 1'b1);
    wait_until(231);
    applyStimulus('0, 1'b0);
    checkOutput("valid_after_ack2", int'(key_valid), 0);

    // Ack held with no key pressed changes nothing.
    wait_until(288);
    applyStimulus('0, 1'b1);
    wait_until(320); checkOutput("valid_ack_idle_c320", int'(key_valid), 0);
    wait_until(352); checkOutput("valid_ack_idle_c352", int'(key_valid), 0);

    // Two keys together: row 3 col 1 and row 6 col 0.
    k = '0;
    k[3][1] = 1'b1;
    k[6][0] = 1'b1;
    applyStimulus(k, 1'b0);
`ifdef KEYPAD_SCAN_MULTI_EN
    wait_until(384); checkOutput("multi_key_c384", int'(multi_key), 1);
    wait_until(416); checkOutput("valid_ghost", int'(key_valid), 0);
`else
    sb.push_back('{code: 13, cycle: 416});
    wait_until(384); checkOutput("multi_key_c384", int'(multi_key), 0);
    wait_until(416); checkOutput("valid_c416", int'(key_valid), 1);
`endif
    wait_until(420);
    applyStimulus('0, 1'b1);
    wait_until(421);
    applyStimulus('0, 1'b0);
    checkOutput("valid_c421", int'(key_valid), 0);
    wait_until(448); checkOutput("multi_key_c448", int'(multi_key), 0);

    // Reset while a key is pending; the still-held key is re-reported.
    wait_until(480);
    applyStimulus(one_key(4, 1), 1'b0);
    sb.push_back('{code: 17, cycle: 544});
    wait_until(549); checkOutput("valid_c549", int'(key_valid), 1);
    wait_until(550);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_key_valid", int'(key_valid), 0);
    checkOutput("rst_row_n", int'(row_n), 8'hFE);
    checkOutput("rst_key_code", int'(key_code), 0);
    sb.push_back('{code: 17, cycle: 64});
    wait_until(70);
    applyStimulus('0, 1'b1);
    wait_until(71);
    applyStimulus('0, 1'b0);
    checkOutput("valid_after_ack3", int'(key_valid), 0);

    wait_until(140);
    checkOutput("pending_events", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
